// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: default widths, the prescale
// floor and the 3-sample majority vote used by the bit sampler.
// Latency: n/a (declarations only). Backpressure: n/a.
package uart_pkg;

  localparam int DEF_PRESC_W   = 6;  // prescale / edge counter width
  localparam int DEF_BIT_W     = 4;  // bit counter / frame length width
  localparam int DEF_MIN_PRESC = 4;  // smallest oversample ratio that still fits 3 strobes

  // Majority of three samples: true when at least two inputs are high.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_majority_sampler.sv
// Captures rx_in on the three sample strobes of a bit and votes the result.
// Latency: bit_valid/sampled_bit one cycle after the third strobe.
// Backpressure: none; strobes arrive at most once per cycle and are always taken.
//
// Ports:
//   CLK, RST        clock and synchronous active-high reset
//   i_stb           sample strobe (one of three per bit)
//   i_third         current strobe is the third of the bit
//   i_rx            synchronised serial input
//   o_bit_valid     1-cycle pulse, o_sampled_bit is fresh this cycle
//   o_sampled_bit   majority of the three samples, held until the next pulse
module uart_rx_majority_sampler
  import uart_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic i_stb,
  input  logic i_third,
  input  logic i_rx,
  output logic o_bit_valid,
  output logic o_sampled_bit
);

  // Only the two earlier samples need storing; the third is voted directly
  // from rx_in on the strobe that captures it.
  logic [1:0] r_s;
  logic       r_bit_valid;
  logic       r_sampled_bit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s           <= '0;
      r_bit_valid   <= 1'b0;
      r_sampled_bit <= 1'b0;
    end else begin
      r_bit_valid <= i_stb & i_third;
      if (i_stb) begin
        r_s <= {r_s[0], i_rx};
      end
      if (i_stb && i_third) begin
        r_sampled_bit <= maj3(r_s[1], r_s[0], i_rx);
      end
    end
  end

  assign o_bit_valid   = r_bit_valid;
  assign o_sampled_bit = r_sampled_bit;

endmodule

// File: rtl/uart_rx_timing_counter.sv
// Oversampling timing engine for the UART receiver: edge/bit counters, sample strobes, boundary pulses.
// Latency: counting starts the cycle enable rises (edge_cnt 0); bit_valid one cycle after the third strobe.
// Backpressure: none; enable low or clear aborts the frame and zeroes the counters next cycle.
//
// Ports:
//   CLK, RST      clock and synchronous active-high reset (RST > clear > enable)
//   enable        count while high; low aborts the frame
//   clear         synchronous restart of counters and cfg_err
//   prescale      oversample edges per bit, latched at frame start
//   frame_bits    bits per frame, latched at frame start
//   rx_in         synchronised serial input
//   edge_cnt      edge index within the bit
//   bit_cnt       bit index within the frame
//   sample_stb    high on edges mid-1, mid, mid+1
//   bit_valid     pulse, sampled_bit fresh
//   sampled_bit   majority-voted bit value
//   bit_done      pulse on the last edge of each bit
//   frame_done    pulse on the last edge of the last bit
//   cfg_err       sticky flag: a clamped configuration was latched
module uart_rx_timing_counter
  import uart_pkg::*;
#(
  parameter int PRESC_W   = DEF_PRESC_W,
  parameter int BIT_W     = DEF_BIT_W,
  parameter int MIN_PRESC = DEF_MIN_PRESC
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] prescale,
  input  logic [BIT_W-1:0]   frame_bits,
  input  logic               rx_in,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sample_stb,
  output logic               bit_valid,
  output logic               sampled_bit,
  output logic               bit_done,
  output logic               frame_done,
  output logic               cfg_err
);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [PRESC_W-1:0] r_presc_q;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BIT_W-1:0]   r_frames_q;
  logic               r_running;
  logic               r_cfg_err;

  logic [PRESC_W-1:0] w_min_presc;
  logic               w_presc_clamp;
  logic               w_frames_clamp;
  logic               w_count;
  logic [PRESC_W-1:0] w_mid;
  logic               w_last_edge;
  logic               w_last_bit;
  logic               w_third;

  assign w_min_presc    = PRESC_W'(MIN_PRESC);
  assign w_presc_clamp  = (prescale < w_min_presc);
  assign w_frames_clamp = (frame_bits == '0);

  // Decodes only act on a cycle that really advances the counters; an
  // aborting cycle (reset, clear or enable low) therefore issues no strobe
  // or boundary pulse for the partial bit.
  assign w_count     = ~RST & ~clear & enable & r_running;
  assign w_mid       = r_presc_q >> 1;
  assign w_last_edge = (r_edge_cnt == r_presc_q - PRESC_W'(1));
  assign w_last_bit  = (r_bit_cnt == r_frames_q - BIT_W'(1));

  assign sample_stb = w_count & ((r_edge_cnt == w_mid - PRESC_W'(1)) ||
                                 (r_edge_cnt == w_mid) ||
                                 (r_edge_cnt == w_mid + PRESC_W'(1)));
  assign w_third    = w_count & (r_edge_cnt == w_mid + PRESC_W'(1));
  assign bit_done   = w_count & w_last_edge;
  assign frame_done = w_count & w_last_edge & w_last_bit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_presc_q  <= w_min_presc;
      r_frames_q <= BIT_W'(1);
      r_running  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else if (clear) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_running  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else if (!enable) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_running  <= 1'b0;
    end else if (!r_running) begin
      // Frame start: this cycle is already edge 0 of bit 0, so the next
      // edge index is 1 (presc_q >= MIN_PRESC, so edge 0 is never last).
      r_running  <= 1'b1;
      r_presc_q  <= w_presc_clamp ? w_min_presc : prescale;
      r_frames_q <= w_frames_clamp ? BIT_W'(1) : frame_bits;
      r_cfg_err  <= r_cfg_err | w_presc_clamp | w_frames_clamp;
      r_edge_cnt <= PRESC_W'(1);
      r_bit_cnt  <= '0;
    end else if (w_last_edge) begin
      r_edge_cnt <= '0;
      if (w_last_bit) begin
        r_bit_cnt <= '0;
        r_running <= 1'b0;
      end else begin
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      end
    end else begin
      r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
    end
  end

  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;
  assign cfg_err  = r_cfg_err;

  uart_rx_majority_sampler u_sampler (
    .CLK           (CLK),
    .RST           (RST),
    .i_stb         (sample_stb),
    .i_third       (w_third),
    .i_rx          (rx_in),
    .o_bit_valid   (bit_valid),
    .o_sampled_bit (sampled_bit)
  );

endmodule

// File: tb/tb_uart_rx_timing_counter.sv
// Directed bench for the UART RX timing engine: frame timing, majority sampling,
// config clamping/latching, abort and reset. Expected values are hand-derived.
module tb_uart_rx_timing_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic [3:0] frame_bits = 4'd10;
  logic       rx_in = 1'b1;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sample_stb;
  logic       bit_valid;
  logic       sampled_bit;
  logic       bit_done;
  logic       frame_done;
  logic       cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  uart_rx_timing_counter dut (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .clear       (clear),
    .prescale    (prescale),
    .frame_bits  (frame_bits),
    .rx_in       (rx_in),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sample_stb  (sample_stb),
    .bit_valid   (bit_valid),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done),
    .frame_done  (frame_done),
    .cfg_err     (cfg_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Samples at edges 3,4,5 of each bit (bit0 = edge3, bit1 = edge4, bit2 = edge5)
  // and the hand-computed majority for each of the 10 bits.
  logic [2:0] vec   [10] = '{3'b101, 3'b000, 3'b111, 3'b011, 3'b100,
                             3'b010, 3'b110, 3'b001, 3'b101, 3'b000};
  logic       vexp  [10] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
                             1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst edge_cnt", edge_cnt, 0);
    chk("rst bit_cnt", bit_cnt, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst bit_valid", bit_valid, 0);
    chk("rst sampled_bit", sampled_bit, 0);
    chk("rst bit_done", bit_done, 0);

    // ---------------- 10-bit frame, prescale 8, majority sampling ----------------
    prescale = 6'd8; frame_bits = 4'd10; enable = 1'b1;
    for (int c = 0; c < 80; c++) begin
      int e, b;
      logic [2:0] v;
      e = c % 8;
      b = c / 8;
      v = vec[b];
      rx_in = (e == 3) ? v[0] : (e == 4) ? v[1] : (e == 5) ? v[2] : 1'b1;
      #1;
      chk($sformatf("f1 edge_cnt c%0d", c), edge_cnt, e);
      chk($sformatf("f1 bit_cnt c%0d", c), bit_cnt, b);
      chk($sformatf("f1 bit_done c%0d", c), bit_done, (e == 7));
      chk($sformatf("f1 frame_done c%0d", c), frame_done, (c == 79));
      chk($sformatf("f1 sample_stb c%0d", c), sample_stb, (e >= 3 && e <= 5));
      chk($sformatf("f1 bit_valid c%0d", c), bit_valid, (e == 6));
      if (e == 6) chk($sformatf("f1 sampled_bit bit%0d", b), sampled_bit, vexp[b]);
      if (e == 7) chk($sformatf("f1 sampled_hold bit%0d", b), sampled_bit, vexp[b]);
      tick();
    end
    rx_in = 1'b1;
    #1;
    chk("f1 b2b edge_cnt", edge_cnt, 0);
    chk("f1 b2b bit_cnt", bit_cnt, 0);
    chk("f1 b2b frame_done", frame_done, 0);
    enable = 1'b0;
    tick();

    // ---------------- config change mid-frame ignored ----------------
    prescale = 6'd8; frame_bits = 4'd5; enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == 24) prescale = 6'd16;
      #1;
      chk($sformatf("f4 edge_cnt c%0d", c), edge_cnt, c % 8);
      chk($sformatf("f4 bit_done c%0d", c), bit_done, (c % 8 == 7));
      chk($sformatf("f4 frame_done c%0d", c), frame_done, (c == 39));
      tick();
    end
    for (int c = 40; c < 56; c++) begin
      #1;
      chk($sformatf("f4 p16 edge_cnt c%0d", c), edge_cnt, c - 40);
      chk($sformatf("f4 p16 bit_done c%0d", c), bit_done, (c == 55));
      tick();
    end
    chk("f4 p16 bit_cnt after bit", bit_cnt, 1);
    enable = 1'b0;
    tick();

    // ---------------- abort at bit 5 edge 6 ----------------
    prescale = 6'd8; frame_bits = 4'd10; enable = 1'b1;
    for (int c = 0; c < 46; c++) tick();
    chk("ab edge_cnt before", edge_cnt, 6);
    chk("ab bit_cnt before", bit_cnt, 5);
    enable = 1'b0;
    #1;
    chk("ab bit_done", bit_done, 0);
    chk("ab frame_done", frame_done, 0);
    tick();
    chk("ab edge_cnt after", edge_cnt, 0);
    chk("ab bit_cnt after", bit_cnt, 0);
    chk("ab bit_done after", bit_done, 0);
    chk("ab bit_valid after", bit_valid, 0);
    tick();
    enable = 1'b1;
    #1;
    chk("ab restart edge0", edge_cnt, 0);
    chk("ab restart bit0", bit_cnt, 0);
    tick();
    chk("ab restart edge1", edge_cnt, 1);
    chk("ab restart bit1", bit_cnt, 0);
    enable = 1'b0;
    tick();

    // ---------------- clamped config, cfg_err ----------------
    chk("ce cfg_err before", cfg_err, 0);
    prescale = 6'd2; frame_bits = 4'd0; enable = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("ce edge_cnt c%0d", c), edge_cnt, c);
      chk($sformatf("ce bit_cnt c%0d", c), bit_cnt, 0);
      chk($sformatf("ce bit_done c%0d", c), bit_done, (c == 3));
      chk($sformatf("ce frame_done c%0d", c), frame_done, (c == 3));
      chk($sformatf("ce cfg_err c%0d", c), cfg_err, (c >= 1));
      tick();
    end
    chk("ce next frame edge", edge_cnt, 0);
    enable = 1'b0;
    tick();
    chk("ce cfg_err sticky on disable", cfg_err, 1);
    clear = 1'b1;
    tick();
    chk("ce cfg_err cleared", cfg_err, 0);
    clear = 1'b0;
    tick();

    // ---------------- prescale 4 timing, then reset mid-frame ----------------
    prescale = 6'd2; frame_bits = 4'd3; rx_in = 1'b1; enable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("p4 sample_stb c%0d", c), sample_stb, (c >= 1 && c <= 3));
      chk($sformatf("p4 bit_valid c%0d", c), bit_valid, (c == 4));
      tick();
    end
    chk("p4 sampled_bit", sampled_bit, 1);
    chk("p4 cfg_err", cfg_err, 1);
    chk("p4 edge_cnt", edge_cnt, 1);
    chk("p4 bit_cnt", bit_cnt, 1);
    RST = 1'b1; clear = 1'b1; enable = 1'b1;
    tick();
    chk("rs edge_cnt", edge_cnt, 0);
    chk("rs bit_cnt", bit_cnt, 0);
    chk("rs sample_stb", sample_stb, 0);
    chk("rs bit_valid", bit_valid, 0);
    chk("rs sampled_bit", sampled_bit, 0);
    chk("rs bit_done", bit_done, 0);
    chk("rs frame_done", frame_done, 0);
    chk("rs cfg_err", cfg_err, 0);
    chk("rs presc_q", dut.r_presc_q, 4);
    chk("rs frames_q", dut.r_frames_q, 1);
    chk("rs running", dut.r_running, 0);
    RST = 1'b0; clear = 1'b0; enable = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
